// File: rtl/netwalk_dpl_pkg.sv
// Shared definitions for the netwalk dataplane: header layout, field offsets
// and the ingress write-FSM state encoding.
package netwalk_dpl_pkg;

   localparam int DPL_DATA_W    = 64;
   localparam int DPL_HDR_BYTES = 64;
   localparam int DPL_META_W    = 64;
   localparam int DPL_LEN_W     = 32;
   localparam int DPL_CNT_W     = 16;
   localparam int DPL_HDR_W     = DPL_LEN_W + DPL_META_W + 8 * DPL_HDR_BYTES;

   localparam int LEN_MSB   = DPL_HDR_W - 1;
   localparam int LEN_LSB   = DPL_HDR_W - DPL_LEN_W;
   localparam int META_MSB  = LEN_LSB - 1;
   localparam int META_LSB  = 8 * DPL_HDR_BYTES;
   localparam int BYTES_MSB = META_LSB - 1;
   localparam int BYTES_LSB = 0;

   // Byte 0 of the packet sits in the top byte of the bytes field.
   typedef struct packed {
      logic [DPL_LEN_W-1:0]       len;
      logic [DPL_META_W-1:0]      meta;
      logic [8*DPL_HDR_BYTES-1:0] bytes;
   } dpl_hdr_t;

   typedef enum logic [0:0] {
      WR_IDLE    = 1'b0,
      WR_COLLECT = 1'b1
   } wr_state_e;

endpackage

// File: rtl/netwalk_hdr_slot_fifo.sv
// Two-entry header FIFO with a registered output; an entry becomes visible on
// the output one cycle after it is pushed and is held until accepted.
module netwalk_hdr_slot_fifo
   import netwalk_dpl_pkg::*;
#(
   parameter int HDR_W = DPL_HDR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [HDR_W-1:0] push_data,
   input  logic             accept,
   output logic             can_push,
   output logic             out_valid,
   output logic [HDR_W-1:0] out_data
);

   logic [HDR_W-1:0] mem [2];

   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [1:0]       avail;
   logic             valid_q, valid_d;
   logic [HDR_W-1:0] data_q, data_d;
   logic             can_push_q, can_push_d;
   logic             pop;

   always_comb begin
      pop        = valid_q & accept;
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      // Only entries completed before this edge may be presented next cycle.
      avail      = count_q - {1'b0, pop};
      valid_d    = (avail != 2'd0);
      data_d     = valid_d ? mem[rd_ptr_d] : data_q;
      can_push_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         can_push_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         can_push_q <= can_push_d;
      end
   end

   assign can_push  = can_push_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/netwalk_header_extractor.sv
// Ingress stage: assembles length, metadata and the first packet bytes from a
// word stream into a header and hands it to the dataplane core.
module netwalk_header_extractor
   import netwalk_dpl_pkg::*;
#(
   parameter int DATA_W    = DPL_DATA_W,
   parameter int HDR_BYTES = DPL_HDR_BYTES,
   parameter int META_W    = DPL_META_W,
   parameter int LEN_W     = DPL_LEN_W,
   parameter int CNT_W     = DPL_CNT_W
) (
   input  logic                                  dpl_clk,
   input  logic                                  dpl_reset,
   input  logic [DATA_W-1:0]                     s_data,
   input  logic                                  s_valid,
   input  logic                                  s_sop,
   input  logic                                  s_eop,
   input  logic [3:0]                            s_keep,
   input  logic [META_W-1:0]                     s_meta,
   output logic                                  s_ready,
   output logic [LEN_W+META_W+8*HDR_BYTES-1:0]   dpl_pkt_header_out,
   output logic                                  dpl_pkt_header_ready,
   input  logic                                  dpl_pkt_header_accept,
   output logic [CNT_W-1:0]                      dpl_drop_count
);

   localparam int WORD_BYTES = DATA_W / 8;
   localparam int HDR_WORDS  = HDR_BYTES / WORD_BYTES;
   localparam int BYTES_W    = 8 * HDR_BYTES;
   localparam int HDR_W      = LEN_W + META_W + BYTES_W;
   localparam int IDX_W      = $clog2(HDR_WORDS + 1);

   wr_state_e          state_q, state_d;
   logic [BYTES_W-1:0] bytes_q, bytes_d;
   logic [META_W-1:0]  meta_q, meta_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   drop_q, drop_d;

   logic               beat;
   logic               push;
   logic               drop_inc;
   logic [3:0]         keep_eff;
   logic [3:0]         beat_len;
   logic [DATA_W-1:0]  keep_mask;
   logic [DATA_W-1:0]  beat_word;
   logic [LEN_W:0]     len_sum;
   logic [LEN_W-1:0]   len_add;

   assign beat     = s_valid & s_ready;
   assign keep_eff = (s_keep == 4'd0 || s_keep > 4'(WORD_BYTES)) ? 4'(WORD_BYTES) : s_keep;
   assign beat_len = s_eop ? keep_eff : 4'(WORD_BYTES);

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_mask
      assign keep_mask[DATA_W-1-8*gi -: 8] = (4'(gi) < keep_eff) ? 8'hFF : 8'h00;
   end

   assign beat_word = s_eop ? (s_data & keep_mask) : s_data;
   assign len_sum   = {1'b0, len_q} + (LEN_W+1)'(beat_len);
   assign len_add   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

   always_comb begin
      state_d  = state_q;
      bytes_d  = bytes_q;
      meta_d   = meta_q;
      len_d    = len_q;
      idx_d    = idx_q;
      drop_inc = 1'b0;
      push     = 1'b0;
      if (beat) begin
         if (s_sop) begin
            // A sop always starts a fresh header, discarding any open packet.
            drop_inc = (state_q == WR_COLLECT);
            bytes_d  = '0;
            bytes_d[BYTES_W-1 -: DATA_W] = beat_word;
            meta_d   = s_meta;
            len_d    = LEN_W'(beat_len);
            idx_d    = IDX_W'(1);
            push     = s_eop;
            state_d  = s_eop ? WR_IDLE : WR_COLLECT;
         end else if (state_q == WR_COLLECT) begin
            for (int w = 1; w < HDR_WORDS; w++) begin
               if (idx_q == IDX_W'(w)) begin
                  bytes_d[BYTES_W-1-w*DATA_W -: DATA_W] = beat_word;
               end
            end
            len_d = len_add;
            if (idx_q != IDX_W'(HDR_WORDS)) begin
               idx_d = idx_q + 1'b1;
            end
            push    = s_eop;
            state_d = s_eop ? WR_IDLE : WR_COLLECT;
         end else begin
            drop_inc = s_eop;
         end
      end
      drop_d = (drop_inc && drop_q != '1) ? drop_q + 1'b1 : drop_q;
   end

   always_ff @(posedge dpl_clk or posedge dpl_reset) begin
      if (dpl_reset) begin
         state_q <= WR_IDLE;
         bytes_q <= '0;
         meta_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         bytes_q <= bytes_d;
         meta_q  <= meta_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
      end
   end

   netwalk_hdr_slot_fifo #(
      .HDR_W (HDR_W)
   ) u_slot_fifo (
      .clk       (dpl_clk),
      .rst       (dpl_reset),
      .push      (push),
      .push_data ({len_d, meta_d, bytes_d}),
      .accept    (dpl_pkt_header_accept),
      .can_push  (s_ready),
      .out_valid (dpl_pkt_header_ready),
      .out_data  (dpl_pkt_header_out)
   );

   assign dpl_drop_count = drop_q;

endmodule

// File: tb/tb_netwalk_header_extractor.sv
// Self-checking bench: table-driven packets plus hand sequences for backpressure,
// aborts, drop-counter saturation and asynchronous reset.
module tb_netwalk_header_extractor;

   logic         dpl_clk = 1'b0;
   logic         dpl_reset;
   logic [63:0]  s_data;
   logic         s_valid, s_sop, s_eop;
   logic [3:0]   s_keep;
   logic [63:0]  s_meta;
   logic         s_ready;
   logic [607:0] dpl_pkt_header_out;
   logic         dpl_pkt_header_ready;
   logic         dpl_pkt_header_accept;
   logic [15:0]  dpl_drop_count;

   int errors = 0;
   int checks = 0;
   logic [607:0] sb_q[$];

   always #5 dpl_clk = ~dpl_clk;

   netwalk_header_extractor dut (
      .dpl_clk               (dpl_clk),
      .dpl_reset             (dpl_reset),
      .s_data                (s_data),
      .s_valid               (s_valid),
      .s_sop                 (s_sop),
      .s_eop                 (s_eop),
      .s_keep                (s_keep),
      .s_meta                (s_meta),
      .s_ready               (s_ready),
      .dpl_pkt_header_out    (dpl_pkt_header_out),
      .dpl_pkt_header_ready  (dpl_pkt_header_ready),
      .dpl_pkt_header_accept (dpl_pkt_header_accept),
      .dpl_drop_count        (dpl_drop_count)
   );

   typedef struct {
      int          nbytes;
      logic [63:0] meta;
      int          seed;
      int          keep_drv;
      logic [31:0] exp_len;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge dpl_clk);
      #1;
   endtask

   function automatic logic [7:0] pkt_byte(input int seed, input int i);
      logic [111:0] arp;
      arp = 112'hffffffffffff0018fe63a30c0806;
      if (seed == 0 && i < 14) return arp[111-8*i -: 8];
      return 8'(((i * 29 + seed * 7) % 255) + 1);
   endfunction

   function automatic logic [607:0] build_hdr(input int nbytes, input logic [31:0] len_field,
                                              input logic [63:0] meta, input int seed);
      logic [607:0] h;
      h = '0;
      h[607:576] = len_field;
      h[575:512] = meta;
      for (int i = 0; i < 64; i++) begin
         if (i < nbytes) h[511-8*i -: 8] = pkt_byte(seed, i);
      end
      return h;
   endfunction

   // stop_after > 0 sends only that many words and no eop (packet left open).
   task automatic send_pkt(input int nbytes, input logic [63:0] meta, input int seed,
                           input int keep_drv, input int stop_after, input logic [31:0] len_field);
      int nw, nsend, rem, n;
      logic [63:0] d;
      nw    = (nbytes + 7) / 8;
      nsend = (stop_after > 0) ? stop_after : nw;
      rem   = nbytes - 8 * (nw - 1);
      if (stop_after == 0) sb_q.push_back(build_hdr(nbytes, len_field, meta, seed));
      for (int w = 0; w < nsend; w++) begin
         for (int b = 0; b < 8; b++) begin
            d[63-8*b -: 8] = (8*w + b < nbytes) ? pkt_byte(seed, 8*w + b) : 8'hA5;
         end
         s_data  = d;
         s_valid = 1'b1;
         s_sop   = (w == 0);
         s_eop   = (stop_after == 0 && w == nw - 1);
         s_meta  = (w == 0) ? meta : ~meta;
         if (s_eop) s_keep = (rem == 8 && keep_drv >= 0) ? 4'(keep_drv) : 4'(rem);
         else       s_keep = 4'($urandom_range(0, 15));
         n = 0;
         while (!s_ready && n < 500) begin
            tick();
            n++;
         end
         if (n >= 500) chk("s_ready_timeout", {63'b0, s_ready}, 64'd1);
         tick();
      end
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   always @(negedge dpl_clk) begin
      if (!dpl_reset && dpl_pkt_header_ready && dpl_pkt_header_accept) begin
         logic [607:0] exp;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL hdr_unexpected: got %h expected none", dpl_pkt_header_out);
         end else begin
            exp = sb_q.pop_front();
            if (dpl_pkt_header_out !== exp) begin
               errors++;
               $display("FAIL hdr: got %h expected %h", dpl_pkt_header_out, exp);
            end else begin
               $display("hdr len=%0d meta=%h ok", exp[607:576], exp[575:512]);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vecs[0] = '{60,  64'hffffffffffffffff, 0, -1, 32'h0000003c};
      vecs[1] = '{114, 64'h0011223344556677, 1, -1, 32'h00000072};
      vecs[2] = '{3,   64'h1000000000000003, 2, -1, 32'h00000003};
      vecs[3] = '{8,   64'h2000000000000008, 3, -1, 32'h00000008};
      vecs[4] = '{64,  64'h3000000000000040, 4, -1, 32'h00000040};
      vecs[5] = '{65,  64'h4000000000000041, 5, -1, 32'h00000041};
      vecs[6] = '{16,  64'h5000000000000010, 6, 0,  32'h00000010};
      vecs[7] = '{24,  64'h6000000000000018, 7, 15, 32'h00000018};
      vecs[8] = '{1,   64'h7000000000000001, 8, -1, 32'h00000001};

      dpl_reset = 1'b1;
      s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_keep = '0; s_meta = '0;
      dpl_pkt_header_accept = 1'b0;
      repeat (3) tick();
      chk("rst_s_ready", {63'b0, s_ready}, 64'd0);
      chk("rst_hdr_ready", {63'b0, dpl_pkt_header_ready}, 64'd0);
      chk("rst_hdr_out", {63'b0, |dpl_pkt_header_out}, 64'd0);
      chk("rst_drop", 64'(dpl_drop_count), 64'd0);
      dpl_reset = 1'b0;
      chk("s_ready_before_edge", {63'b0, s_ready}, 64'd0);
      tick();
      chk("s_ready_after_edge", {63'b0, s_ready}, 64'd1);

      // ARP packet with latency and field spot checks
      dpl_pkt_header_accept = 1'b1;
      send_pkt(60, 64'hffffffffffffffff, 0, -1, 0, 32'h0000003c);
      chk("arp_ready_eop_cycle", {63'b0, dpl_pkt_header_ready}, 64'd0);
      tick();
      chk("arp_ready", {63'b0, dpl_pkt_header_ready}, 64'd1);
      chk("arp_len", 64'(dpl_pkt_header_out[607:576]), 64'h3c);
      chk("arp_meta", dpl_pkt_header_out[575:512], 64'hffffffffffffffff);
      chk("arp_bytes0", dpl_pkt_header_out[511:448], 64'hffffffffffff0018);
      chk("arp_tail", 64'(dpl_pkt_header_out[31:0]), 64'd0);
      tick();
      chk("arp_ready_1cycle", {63'b0, dpl_pkt_header_ready}, 64'd0);

      for (int v = 0; v < 9; v++) begin
         send_pkt(vecs[v].nbytes, vecs[v].meta, vecs[v].seed, vecs[v].keep_drv, 0, vecs[v].exp_len);
         drain();
      end
      chk("no_drop_after_table", 64'(dpl_drop_count), 64'd0);

      // Backpressure: two pending headers stall the third packet at its sop
      dpl_pkt_header_accept = 1'b0;
      send_pkt(60, 64'hA1, 11, -1, 0, 32'd60);
      send_pkt(60, 64'hA2, 12, -1, 0, 32'd60);
      chk("s_ready_full", {63'b0, s_ready}, 64'd0);
      fork
         send_pkt(60, 64'hA3, 13, -1, 0, 32'd60);
         begin
            repeat (3) tick();
            chk("s_ready_stalled", {63'b0, s_ready}, 64'd0);
            chk("hdr_pending", {63'b0, dpl_pkt_header_ready}, 64'd1);
            dpl_pkt_header_accept = 1'b1;
            tick();
            dpl_pkt_header_accept = 1'b0;
            chk("s_ready_reassert", {63'b0, s_ready}, 64'd1);
         end
      join
      dpl_pkt_header_accept = 1'b1;
      drain();

      // Aborts: sop at beat 4, stray eop, sop+eop mid-packet
      send_pkt(40, 64'hB1, 21, -1, 4, 32'd0);
      send_pkt(30, 64'hB2, 22, -1, 0, 32'd30);
      drain();
      chk("drop_abort", 64'(dpl_drop_count), 64'd1);
      s_valid = 1'b1; s_eop = 1'b1; s_sop = 1'b0; s_data = 64'hdeadbeefdeadbeef;
      tick();
      s_valid = 1'b0; s_eop = 1'b0;
      tick();
      chk("drop_stray_eop", 64'(dpl_drop_count), 64'd2);
      chk("stray_no_hdr", {63'b0, dpl_pkt_header_ready}, 64'd0);
      send_pkt(20, 64'hB3, 23, -1, 2, 32'd0);
      send_pkt(5, 64'hB4, 24, -1, 0, 32'd5);
      drain();
      chk("drop_sop_eop_abort", 64'(dpl_drop_count), 64'd3);

      // Drop counter saturation
      s_valid = 1'b1; s_eop = 1'b1; s_sop = 1'b0;
      repeat (65531) tick();
      chk("drop_near_max", 64'(dpl_drop_count), 64'hfffe);
      repeat (4) tick();
      s_valid = 1'b0; s_eop = 1'b0;
      tick();
      chk("drop_saturated", 64'(dpl_drop_count), 64'hffff);

      // Asynchronous reset mid-packet with one header pending
      dpl_pkt_header_accept = 1'b0;
      send_pkt(60, 64'hC1, 31, -1, 0, 32'd60);
      repeat (2) tick();
      chk("pending_before_rst", {63'b0, dpl_pkt_header_ready}, 64'd1);
      send_pkt(60, 64'hC2, 32, -1, 3, 32'd0);
      #2;
      dpl_reset = 1'b1;
      #1;
      chk("arst_hdr_ready", {63'b0, dpl_pkt_header_ready}, 64'd0);
      chk("arst_drop", 64'(dpl_drop_count), 64'd0);
      chk("arst_s_ready", {63'b0, s_ready}, 64'd0);
      chk("arst_hdr_out", {63'b0, |dpl_pkt_header_out}, 64'd0);
      sb_q.delete();
      tick();
      dpl_reset = 1'b0;
      tick();
      chk("post_rst_s_ready", {63'b0, s_ready}, 64'd1);
      dpl_pkt_header_accept = 1'b1;
      send_pkt(60, 64'hC3, 33, -1, 0, 32'd60);
      drain();
      chk("post_rst_drop", 64'(dpl_drop_count), 64'd0);
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
